// File: rtl/rr_arb_8_if.sv
// rr_arb_8_if: request/grant bundle between the requesters and the round-robin arbiter
interface rr_arb_8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (output req, output done, input gnt, input gnt_idx, input gnt_valid, input timeout);
    modport slave  (input req, input done, output gnt, output gnt_idx, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_arb_8.sv
// rr_arb_8: 8-way round-robin arbiter with hold-time limit and decoder-driven one-hot grant

// dec_3x8: 3-to-8 one-hot decoder
module dec_3x8 (
    input  logic [2:0] sel,
    output logic [7:0] y
);
    assign y = 8'd1 << sel;
endmodule

module rr_arb_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    rr_arb_8_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [2:0]       idx;
    logic             valid;
    logic             tmo;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      req2;
    logic [7:0]       rot;
    logic [2:0]       off;
    logic [2:0]       sel;
    logic             lim;
    logic             drop;
    logic             rel;
    logic [7:0]       dec;

    // rotate requests so the pointer position is bit 0, then pick the lowest set bit
    always_comb begin
        req2 = {bus.req, bus.req} >> ptr;
        rot  = req2[7:0];
        off  = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (rot[i]) off = 3'(i);
        sel  = ptr + off;
        lim  = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD));
        drop = !bus.req[idx];
        rel  = bus.done || drop || lim;
    end

    // grant sequencing: IDLE picks an owner, GRANT holds it until done, drop or limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd0;
            idx   <= 3'd0;
            valid <= 1'b0;
            tmo   <= 1'b0;
            cnt   <= '0;
        end else begin
            tmo <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        idx   <= sel;
                        valid <= 1'b1;
                        cnt   <= CNT_W'(1);
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        valid <= 1'b0;
                        ptr   <= idx + 3'd1;
                        cnt   <= '0;
                        tmo   <= lim && !bus.done && !drop;
                        state <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    valid <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    dec_3x8 u_dec (.sel(idx), .y(dec));

    assign bus.gnt       = dec & {8{valid}};
    assign bus.gnt_idx   = idx;
    assign bus.gnt_valid = valid;
    assign bus.timeout   = tmo;
endmodule

// File: tb/tb_rr_arb_8.sv
// tb_rr_arb_8: directed self-checking bench for rr_arb_8 (MAX_HOLD=4)
module tb_rr_arb_8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    rr_arb_8_if bus ();

    rr_arb_8 #(.MAX_HOLD(4), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkg(input string tag, input logic [7:0] exp);
        chk({tag, ".gnt"}, bus.gnt, exp);
        chk({tag, ".valid"}, {7'd0, bus.gnt_valid}, {7'd0, exp != 8'h00});
    endtask

    // invariant: grant one-hot or zero, and matches the decoded index while valid
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert ($onehot0(bus.gnt) && (!bus.gnt_valid || bus.gnt === (8'd1 << bus.gnt_idx))) else begin
                failures++;
                $error("FAIL invariant gnt=%0h idx=%0d valid=%0b", bus.gnt, bus.gnt_idx, bus.gnt_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = 8'hFF;
        bus.done = 1'b0;
        #23;
        chkg("rst", 8'h00);
        chk("rst.idx", {5'd0, bus.gnt_idx}, 8'd0);
        chk("rst.tmo", {7'd0, bus.timeout}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chkg("rst_rel", 8'h00);
        step;
        // full contention: each grant released by done on its 2nd cycle
        for (int k = 0; k < 9; k++) begin
            chkg("rr_first", 8'd1 << (k % 8));
            step;
            chkg("rr_second", 8'd1 << (k % 8));
            bus.done = 1'b1;
            step;
            bus.done = 1'b0;
            chkg("rr_gap", 8'h00);
            step;
        end
        // now granted idx 1; dropping request releases it, ptr=2
        chkg("rr_next", 8'h02);
        bus.req = 8'h00;
        step;
        chkg("drop_all", 8'h00);
        // owner 5 to put ptr at 6
        bus.req = 8'h20;
        step;
        chkg("own5", 8'h20);
        bus.done = 1'b1;
        step;
        chkg("own5_rel", 8'h00);
        bus.done = 1'b0;
        bus.req  = 8'h05;
        step;
        chkg("wrap0", 8'h01);
        chk("wrap0.idx", {5'd0, bus.gnt_idx}, 8'd0);
        bus.done = 1'b1;
        step;
        chkg("wrap0_rel", 8'h00);
        bus.done = 1'b0;
        step;
        chkg("wrap2", 8'h04);
        bus.done = 1'b1;
        step;
        bus.done = 1'b0;
        bus.req  = 8'h00;
        chkg("wrap2_rel", 8'h00);
        step;
        chkg("idle", 8'h00);
        // timeout: req[3] held, ptr=3
        bus.req = 8'h08;
        for (int k = 0; k < 4; k++) begin
            step;
            chkg("hold", 8'h08);
            chk("hold.tmo", {7'd0, bus.timeout}, 8'd0);
        end
        step;
        chkg("tmo_rel", 8'h00);
        chk("tmo_pulse", {7'd0, bus.timeout}, 8'd1);
        step;
        chkg("regrant", 8'h08);
        chk("tmo_clear", {7'd0, bus.timeout}, 8'd0);
        // done coincides with limit: no timeout
        step;
        step;
        step;
        chkg("lim_done_pre", 8'h08);
        bus.done = 1'b1;
        step;
        chkg("lim_done_rel", 8'h00);
        chk("lim_done_tmo", {7'd0, bus.timeout}, 8'd0);
        bus.done = 1'b0;
        step;
        chkg("lim_drop_g", 8'h08);
        step;
        step;
        step;
        bus.req = 8'h00;
        step;
        chkg("lim_drop_rel", 8'h00);
        chk("lim_drop_tmo", {7'd0, bus.timeout}, 8'd0);
        // request drop mid-grant, ptr=4
        bus.req = 8'h06;
        step;
        chkg("drop_g", 8'h02);
        step;
        chkg("drop_hold", 8'h02);
        bus.req = 8'h04;
        step;
        chkg("drop_rel", 8'h00);
        step;
        chkg("drop_next", 8'h04);
        bus.req = 8'h10;
        step;
        chkg("pre_rst_gap", 8'h00);
        step;
        chkg("pre_rst", 8'h10);
        // reset mid-grant
        #2;
        rst_n = 1'b0;
        #1;
        chkg("async_rst", 8'h00);
        chk("async_rst.idx", {5'd0, bus.gnt_idx}, 8'd0);
        bus.req = 8'h30;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chkg("rst2_rel", 8'h00);
        step;
        chkg("post_rst", 8'h10);
        chk("post_rst.idx", {5'd0, bus.gnt_idx}, 8'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_arb_8.md
Name: rr_arb_8

Overview:
- 8-requester round-robin arbiter that shares one resource slot.
- Converts a registered 3-bit grant index into a one-hot 8-bit grant using the team's 3-to-8 decoder (dec_3x8), gated by grant-valid.
- Sequences ownership as request → grant → hold → release, with an optional hold-time limit.
- Sits in front of any shared datapath whose select lines are decoder-driven.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 disables the timeout.
- CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i.
- done  input  1  current owner releases at end of this cycle.
- gnt  output  8  one-hot grant = dec_3x8(gnt_idx) AND {8{gnt_valid}}.
- gnt_idx  output  3  index of current owner; holds last value when idle.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=3'd0, hold counter=0, state=IDLE.
- States: IDLE, GRANT. Only these two; illegal encodings return to IDLE.
- IDLE:
  - gnt_valid=0.
  - If req!=0, select the first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - Next edge: gnt_idx=selected, gnt_valid=1, counter=1, state=GRANT.
  - Latency from req sampled in IDLE to gnt: exactly 1 cycle.
  - If req==0, stay in IDLE.
- GRANT:
  - Outputs are stable; requests from other requesters are ignored.
  - Release condition on a sampled edge: done=1, OR req[gnt_idx]=0, OR (MAX_HOLD!=0 AND counter==MAX_HOLD).
  - On release, next edge: gnt_valid=0, ptr=gnt_idx+1 (3-bit wrap, 7→0), counter=0, state=IDLE.
  - Otherwise counter increments, saturating at its maximum.
- timeout:
  - Asserted for the single cycle following a release caused only by the counter limit.
  - Not asserted if done or a request drop coincides with the limit; done/drop take precedence.
- Break-before-make: at least one cycle with gnt=0 between any two owners, including back-to-back requests from the same requester.
- Fairness:
  - A requester holding req continuously is granted within 8 grant periods.
  - The owner just released has lowest priority next.
- gnt must always be one-hot or zero; no glitch paths (gnt is a combinational decode of registered signals only).
- req and done are synchronous to clk; no internal synchronisers.
- Reset mid-GRANT: outputs drop immediately (async), ptr returns to 0.

Test Plan:
- Reset with req=8'hFF → gnt=8'h00, gnt_valid=0, gnt_idx=0 while rst_n=0. After release: gnt=8'h01 one cycle later.
- Full contention: req=8'hFF, done pulsed on the 2nd cycle of every grant → gnt sequence 01,02,04,08,10,20,40,80,01, each separated by one zero cycle.
- Sparse + wrap: ptr at 6 (last owner 5), req=8'b0000_0101 → grant idx 0 (gnt=8'h01), then idx 2 (gnt=8'h04).
- Timeout: MAX_HOLD=4, req[3] held high, done=0 → gnt=8'h08 for exactly 4 cycles, timeout=1 on the following cycle, then the next requester or idle.
- Simultaneous events: done=1 on the same cycle the counter hits MAX_HOLD → release with timeout=0. req[owner] dropping mid-grant → release next edge.
- Reset mid-grant: rst_n low while gnt=8'h10 → gnt=8'h00 immediately. After deassert with req=8'h30 → gnt=8'h10 (ptr back to 0).
- Every scenario: checker asserts $onehot0(gnt) and gnt==dec_3x8(gnt_idx) whenever gnt_valid=1.
